dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory between the CPU core's DMEM port and an external host port used for loading, inspection and debug. It sits between CPU_TOP and the DMEM macro and drives the core's `en` input, freezing the pipeline while the host owns memory. Host access comes in bounded bursts, and the CPU is guaranteed a minimum run window between bursts.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_if
//  Purpose  : CPU, host and memory-side signal bundle of the DMEM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    logic        run_en;
    logic        cpu_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  run_en, cpu_addr, cpu_wdata, cpu_we,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_en, cpu_rdata, host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output run_en, cpu_addr, cpu_wdata, cpu_we,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_en, cpu_rdata, host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares single-port DMEM between the CPU and a bursting host port.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CPU_MIN   = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int c_run_w   = $clog2(CPU_MIN + 1);
    localparam int c_burst_w = $clog2(MAX_BURST + 1);

    localparam logic [c_run_w-1:0]   c_run_max    = c_run_w'(CPU_MIN);
    localparam logic [c_run_w-1:0]   c_run_one    = c_run_w'(1);
    localparam logic [c_burst_w-1:0] c_burst_max  = c_burst_w'(MAX_BURST);
    localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(MAX_BURST - 1);
    localparam logic [c_burst_w-1:0] c_burst_one  = c_burst_w'(1);

    localparam logic [1:0] c_st_cpu   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_host  = 2'd2;
    localparam logic [1:0] c_st_tail  = 2'd3;

    logic [1:0]           r_state;
    logic [c_run_w-1:0]   r_run_cnt;
    logic [c_burst_w-1:0] r_burst_cnt;
    logic [31:0]          r_hold;
    logic                 r_rd_pend;

    logic        w_host_gnt;
    logic        w_cpu_en;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_cpu_rdata;

    assign w_host_gnt = !rst && (r_state == c_st_host) && bus.host_req
                        && (r_burst_cnt < c_burst_max);

    always_comb begin
        w_cpu_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.cpu_addr;
        w_mem_wdata = bus.cpu_wdata;
        case (r_state)
            c_st_cpu: begin
                w_cpu_en = bus.run_en;
                w_mem_we = bus.cpu_we & bus.run_en;
            end
            c_st_host: begin
                w_mem_addr  = bus.host_addr;
                w_mem_wdata = bus.host_wdata;
                w_mem_we    = w_host_gnt & bus.host_we;
            end
            default: ;
        endcase
        if (rst) begin
            w_cpu_en    = 1'b0;
            w_mem_we    = 1'b0;
            w_mem_addr  = 32'd0;
            w_mem_wdata = 32'd0;
        end
    end

    // DRAIN forwards the value being captured so the frozen load result never glitches
    always_comb begin
        w_cpu_rdata = r_hold;
        if (rst)
            w_cpu_rdata = 32'd0;
        else if (w_cpu_en || (r_state == c_st_drain))
            w_cpu_rdata = bus.mem_rdata;
    end

    assign bus.cpu_en      = w_cpu_en;
    assign bus.cpu_rdata   = w_cpu_rdata;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.host_rvalid = !rst && r_rd_pend;
    assign bus.host_rdata  = rst ? 32'd0 : bus.mem_rdata;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
    assign bus.mem_we      = w_mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_cpu;
            r_run_cnt   <= '0;
            r_burst_cnt <= '0;
            r_hold      <= 32'd0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_rd_pend <= w_host_gnt & ~bus.host_we;
            case (r_state)
                c_st_cpu: begin
                    if (bus.run_en && (r_run_cnt < c_run_max))
                        r_run_cnt <= r_run_cnt + c_run_one;
                    // an idle CPU waives its guaranteed run window
                    if (bus.host_req && ((r_run_cnt == c_run_max) || !bus.run_en))
                        r_state <= c_st_drain;
                end
                c_st_drain: begin
                    r_hold  <= bus.mem_rdata;
                    r_state <= c_st_host;
                end
                c_st_host: begin
                    if (w_host_gnt)
                        r_burst_cnt <= r_burst_cnt + c_burst_one;
                    if (!bus.host_req || (w_host_gnt && (r_burst_cnt == c_burst_last)))
                        r_state <= c_st_tail;
                end
                c_st_tail: begin
                    r_run_cnt   <= '0;
                    r_burst_cnt <= '0;
                    r_state     <= c_st_cpu;
                end
                default: r_state <= c_st_cpu;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed scoreboard bench for dmem_arbiter with a 1-cycle memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int MAX_BURST = 8;
    localparam int CPU_MIN   = 4;
    localparam int NB        = 28;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if bus();

    dmem_arbiter #(.MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory content before any write: two marked words, otherwise a tagged index
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'd8)  return 32'h1234_5678;
        if (idx == 8'd16) return 32'hA5A5_A5A5;
        return 32'hC0DE_0000 | {24'd0, idx};
    endfunction

    logic [31:0] mem     [256];
    logic        written [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]]     <= bus.mem_wdata;
            written[bus.mem_addr[9:2]] <= 1'b1;
        end
        bus.mem_rdata <= written[bus.mem_addr[9:2]] ? mem[bus.mem_addr[9:2]]
                                                    : init_word(bus.mem_addr[9:2]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One host access; lat = cycles from request to grant
    task automatic host_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, output int lat);
        bit got = 1'b0;
        lat = -1;
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.host_gnt) begin
                got = 1'b1;
                lat = i;
                if (!we) sb.push_back('{due: cyc + 1, data: exp});
            end
            step();
        end
        chk("host_gnt_seen", {31'd0, got}, 32'd1);
        bus.host_req = 1'b0;
    endtask

    // Wait for CPU state, then satisfy the CPU run window
    task automatic settle();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.cpu_en) seen = 1'b1;
            step();
        end
        chk("cpu_resume_seen", {31'd0, seen}, 32'd1);
        repeat (CPU_MIN - 1) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int lat;
        int ng;
        int nfrz;
        bit g [NB];
        bit e [NB];
        bit aborted;

        bus.run_en = 1'b1; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0; bus.cpu_we = 1'b0;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'd0; bus.host_wdata = 32'd0;

        fork
            forever begin
                @(negedge clk);
                if (bus.host_rvalid) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        exp_t x;
                        x = sb.pop_front();
                        chk("rvalid_cycle", cyc, x.due);
                        chk("host_rdata", bus.host_rdata, x.data);
                    end
                end else if (sb.size() != 0 && sb[0].due < cyc) begin
                    chk("rvalid_missing", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        join_none

        // Reset held with host_req and run_en high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
            chk("rst_host_gnt", {31'd0, bus.host_gnt}, 32'd0);
            chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
            chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
            chk("rst_host_rdata", bus.host_rdata, 32'd0);
            chk("rst_mem_addr", bus.mem_addr, 32'd0);
            step();
        end
        rst = 1'b0;
        bus.host_req = 1'b0;
        @(negedge clk);
        chk("post_rst_cpu_en", {31'd0, bus.cpu_en}, 32'd1);
        repeat (CPU_MIN) step();

        // Host entry and single write
        bus.host_req = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 32'h10; bus.host_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("entry_cpu_en", {31'd0, bus.cpu_en}, 32'd1);
        chk("entry_gnt", {31'd0, bus.host_gnt}, 32'd0);
        step();
        @(negedge clk);
        chk("drain_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        chk("drain_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("drain_gnt", {31'd0, bus.host_gnt}, 32'd0);
        step();
        @(negedge clk);
        chk("wr_gnt", {31'd0, bus.host_gnt}, 32'd1);
        chk("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
        chk("wr_mem_addr", bus.mem_addr, 32'h10);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        bus.host_req = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {31'd0, bus.host_gnt}, 32'd0);
        chk("idle_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("idle_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        step();
        @(negedge clk);
        chk("tail_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        chk("tail_mem_we", {31'd0, bus.mem_we}, 32'd0);
        step();
        @(negedge clk);
        chk("resume_cpu_en", {31'd0, bus.cpu_en}, 32'd1);
        repeat (CPU_MIN) step();

        // Host reads: marked word, then the word written above
        host_op(1'b0, 32'h20, 32'd0, 32'h1234_5678, lat);
        chk("entry_latency", lat, 32'd2);
        host_op(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, lat);
        chk("b2b_latency", lat, 32'd0);

        // Burst cap with host_req held continuously
        settle();
        ng = 0;
        for (int i = 0; i < NB; i++) begin
            bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h200 + 32'(4 * ng);
            @(negedge clk);
            g[i] = bus.host_gnt;
            e[i] = bus.cpu_en;
            if (bus.host_gnt) begin
                sb.push_back('{due: cyc + 1, data: 32'hC0DE_0000 | (32'h80 + 32'(ng))});
                ng++;
            end
            step();
        end
        bus.host_req = 1'b0;
        begin
            int f1 = 0, len1 = 0, l1, j, n_en = 0, len2 = 0, both = 0;
            while (f1 < NB && !g[f1]) f1++;
            j = f1;
            while (j < NB && g[j]) begin len1++; j++; end
            l1 = (len1 > 0) ? f1 + len1 - 1 : NB - 3;
            if (l1 > NB - 3) l1 = NB - 3;
            chk("burst1_len", len1, MAX_BURST);
            chk("burst1_tail_en", {31'd0, e[l1 + 1]}, 32'd0);
            chk("burst1_resume_en", {31'd0, e[l1 + 2]}, 32'd1);
            j = l1 + 1;
            while (j < NB && !g[j]) begin if (e[j]) n_en++; j++; end
            while (j < NB && g[j]) begin len2++; j++; end
            chk("cpu_window_min", {31'd0, n_en >= CPU_MIN}, 32'd1);
            chk("burst2_len", len2, MAX_BURST);
            for (int k = 0; k < NB; k++) if (g[k] && e[k]) both++;
            chk("gnt_cpu_exclusive", both, 32'd0);
        end

        // CPU load in the cycle the FSM leaves CPU stays visible through the freeze
        settle();
        bus.cpu_addr = 32'h40; bus.cpu_we = 1'b0;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h24;
        @(negedge clk);
        chk("freeze_entry_en", {31'd0, bus.cpu_en}, 32'd1);
        step();
        bus.cpu_addr = 32'h0;
        ng = 0;
        nfrz = 0;
        for (int i = 0; i < 20; i++) begin
            bus.host_req = (ng < 2);
            bus.host_addr = 32'h24 + 32'(4 * ng);
            @(negedge clk);
            if (bus.cpu_en) break;
            nfrz++;
            chk("frozen_cpu_rdata", bus.cpu_rdata, 32'hA5A5_A5A5);
            if (bus.host_gnt) begin
                sb.push_back('{due: cyc + 1, data: 32'hC0DE_0000 | (32'd9 + 32'(ng))});
                ng++;
            end
            step();
        end
        chk("freeze_cycles", nfrz, 32'd5);
        step();

        // run_en low: CPU disabled, no CPU writes, window waived
        bus.run_en = 1'b0; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("idle_cpu_en_low", {31'd0, bus.cpu_en}, 32'd0);
        chk("idle_cpu_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("idle_cpu_rdata_hold", bus.cpu_rdata, 32'hA5A5_A5A5);
        step();
        host_op(1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, lat);
        chk("waived_latency", lat, 32'd2);
        bus.run_en = 1'b1; bus.cpu_we = 1'b0;

        // Reset on the 3rd grant of a read burst
        settle();
        ng = 0;
        aborted = 1'b0;
        for (int i = 0; i < 20 && !aborted; i++) begin
            bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'h300 + 32'(4 * ng);
            @(negedge clk);
            if (bus.host_gnt) begin
                ng++;
                if (ng == 3) aborted = 1'b1;
                else sb.push_back('{due: cyc + 1, data: 32'hC0DE_0000 | (32'hC0 + 32'(ng - 1))});
            end
            step();
        end
        chk("abort_reached", {31'd0, aborted}, 32'd1);
        rst = 1'b1;
        bus.host_req = 1'b0;
        @(negedge clk);
        chk("abort_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        chk("abort_cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_resume_en", {31'd0, bus.cpu_en}, 32'd1);
        chk("abort_resume_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
